// File: rtl/mcctrl_pkg.sv
// Shared types and encodings for the multicycle ARMv4-subset controller.
// Optional memory wait states are enabled with `define MCCTRL_MEMWAIT_EN.
package mcctrl_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Returns {known, alu_control} for a DP cmd field.
  function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
    logic [2:0] r;
    unique case (cmd)
      CMD_ADD: r = {1'b1, ALU_ADD};
      CMD_SUB: r = {1'b1, ALU_SUB};
      CMD_AND: r = {1'b1, ALU_AND};
      CMD_ORR: r = {1'b1, ALU_ORR};
      default: r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mcctrl_condcheck.sv
// ARM condition-code evaluation against the NZCV flag register.
module mcctrl_condcheck
  import mcctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  always_comb begin
    cond_ex_o = 1'b0;
    unique case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = ~z & (n == v);
      COND_LE: cond_ex_o = z | (n != v);
      COND_AL: cond_ex_o = 1'b1;
      COND_NV: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style multicycle controller: FSM, NZCV flag register and state decode.
// `define MCCTRL_MEMWAIT_EN adds mem_ready wait states in FETCH/MEMRD/MEMWR.
module multicycle_ctrl
  import mcctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MCCTRL_MEMWAIT_EN
  input  logic        mem_ready,
`endif
  input  logic [19:0] instr,
  input  logic [3:0]  alu_flags,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  result_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_control,
  output logic [1:0]  imm_src,
  output logic [1:0]  reg_src,
  output logic        reg_write,
  output logic [3:0]  state_o
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = instr[19:16];
  assign op        = instr[15:14];
  assign funct     = instr[13:8];
  assign rd        = instr[3:0];
  assign unused_rn = ^instr[7:4];

  logic mem_rdy;
`ifdef MCCTRL_MEMWAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex;
  logic [2:0] alu_dec;
  logic       cmd_ok;
  logic       is_arith;
  logic       rd_pc;

  assign alu_dec  = alu_decode(funct[4:1]);
  assign cmd_ok   = alu_dec[2];
  assign is_arith = cmd_ok & ((alu_dec[1:0] == ALU_ADD) | (alu_dec[1:0] == ALU_SUB));
  assign rd_pc    = (rd == 4'd15);

  mcctrl_condcheck u_condcheck (
    .cond_i    (cond),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = mem_rdy ? StDecode : StFetch;
      StDecode: begin
        unique case (op)
          OP_MEM:  state_d = StMemAdr;
          OP_DP:   state_d = funct[5] ? StExecI : StExecR;
          OP_B:    state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = funct[0] ? StMemRd : StMemWr;
      StMemRd:  state_d = mem_rdy ? StMemWb : StMemRd;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = mem_rdy ? StFetch : StMemWr;
      StExecR:  state_d = StAluWb;
      StExecI:  state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Flags are captured on the edge leaving EXECR/EXECI; C and V only for arithmetic ops.
  always_comb begin
    flags_d = flags_q;
    if ((state_q == StExecR || state_q == StExecI) && funct[0] && cond_ex && cmd_ok) begin
      flags_d[3:2] = alu_flags[3:2];
      if (is_arith) flags_d[1:0] = alu_flags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      flags_q <= FLAGS_RST;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RD2;
    alu_control = ALU_ADD;
    reg_write   = 1'b0;
    case (state_q)
      StFetch: begin
        ir_write   = mem_rdy;
        pc_write   = mem_rdy;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      StDecode: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      StMemAdr: alu_src_b = SRCB_EXTIMM;
      StMemRd:  adr_src = 1'b1;
      StMemWb: begin
        result_src = RES_DATA;
        reg_write  = cond_ex;
        pc_write   = cond_ex & rd_pc;
      end
      StMemWr: begin
        adr_src   = 1'b1;
        mem_write = cond_ex & mem_rdy;
      end
      StExecR: alu_control = alu_dec[1:0];
      StExecI: begin
        alu_src_b   = SRCB_EXTIMM;
        alu_control = alu_dec[1:0];
      end
      StAluWb: begin
        result_src = RES_ALUOUT;
        reg_write  = cond_ex & cmd_ok;
        pc_write   = cond_ex & cmd_ok & rd_pc;
      end
      StBranch: begin
        alu_src_b  = SRCB_EXTIMM;
        result_src = RES_ALURESULT;
        pc_write   = cond_ex;
      end
      default: ;
    endcase
    // Architectural writes must be quiet for the whole reset pulse, not just after the edge.
    if (reset) begin
      pc_write  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  always_comb begin
    imm_src = IMM_8;
    reg_src = 2'b00;
    unique case (op)
      OP_MEM: begin
        imm_src = IMM_12;
        reg_src = funct[0] ? 2'b00 : 2'b10;
      end
      OP_B: begin
        imm_src = IMM_24;
        reg_src = 2'b01;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases plus random instruction stream
// checked against an instruction-level reference model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] instr;
  logic [3:0]  alu_flags;
  logic        pc_write, adr_src, mem_write, ir_write, alu_src_a, reg_write;
  logic [1:0]  result_src, alu_src_b, alu_control, imm_src, reg_src;
  logic [3:0]  state_o;
`ifdef MCCTRL_MEMWAIT_EN
  logic        mem_ready = 1'b1;
`endif

  int checks   = 0;
  int failures = 0;
  logic [3:0] m_flags;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic       reg_write;
    logic [3:0] state;
  } outs_t;

  typedef int path_t[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.FLAGS_RST(4'b0000)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef MCCTRL_MEMWAIT_EN
    .mem_ready   (mem_ready),
`endif
    .instr       (instr),
    .alu_flags   (alu_flags),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .imm_src     (imm_src),
    .reg_src     (reg_src),
    .reg_write   (reg_write),
    .state_o     (state_o)
  );

  // ARM conditions come in true/inverted pairs; 1110 is always and 1111 never.
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0:    b = z;
      3'd1:    b = cy;
      3'd2:    b = n;
      3'd3:    b = v;
      3'd4:    b = cy && !z;
      3'd5:    b = (n == v);
      3'd6:    b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return c[0] ? !b : b;
  endfunction

  function automatic int alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 0;
      4'b0010: return 1;
      4'b0000: return 2;
      4'b1100: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic path_t path_of(input logic [19:0] ins);
    path_t p;
    case (ins[15:14])
      2'b01:   p = ins[8] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
      2'b00:   p = ins[13] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
      2'b10:   p = '{0, 1, 9};
      default: p = '{0, 1};
    endcase
    return p;
  endfunction

  function automatic outs_t model_outs(input int st, input logic [19:0] ins,
                                       input logic [3:0] fl);
    outs_t o;
    bit    cex;
    int    aop;
    o   = '0;
    cex = cond_holds(ins[19:16], fl);
    aop = alu_of(ins[12:9]);
    o.state = 4'(st);
    if (st != 0) begin
      if (ins[15:14] == 2'b01) begin
        o.imm_src = 2'b01;
        o.reg_src = ins[8] ? 2'b00 : 2'b10;
      end else if (ins[15:14] == 2'b10) begin
        o.imm_src = 2'b10;
        o.reg_src = 2'b01;
      end
    end
    case (st)
      0: begin o.ir_write = 1; o.pc_write = 1; o.alu_src_a = 1; o.alu_src_b = 2; o.result_src = 2; end
      1: begin o.alu_src_a = 1; o.alu_src_b = 2; o.result_src = 2; end
      2: o.alu_src_b = 1;
      3: o.adr_src = 1;
      4: begin o.result_src = 1; o.reg_write = cex; o.pc_write = cex && ins[3:0] == 15; end
      5: begin o.adr_src = 1; o.mem_write = cex; end
      6: o.alu_control = (aop < 0) ? 2'd0 : 2'(aop);
      7: begin o.alu_src_b = 1; o.alu_control = (aop < 0) ? 2'd0 : 2'(aop); end
      8: begin
        o.reg_write = cex && aop >= 0;
        o.pc_write  = o.reg_write && ins[3:0] == 15;
      end
      9: begin o.alu_src_b = 1; o.result_src = 2; o.pc_write = cex; end
      default: ;
    endcase
    return o;
  endfunction

  // Called just after a posedge with the DUT in FETCH; runs up to nmax states of one instruction.
  task automatic run_instr(input logic [19:0] ins, input bit fix_af, input logic [3:0] af,
                           input int nmax);
    path_t p;
    outs_t exp_o, got;
    int    aop;
    p     = path_of(ins);
    instr = ins;
    for (int k = 0; k < p.size() && k < nmax; k++) begin
      alu_flags = fix_af ? af : 4'($urandom);
      #1;
      exp_o = model_outs(p[k], ins, m_flags);
      got   = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
               alu_control, imm_src, reg_src, reg_write, state_o};
      if (p[k] == 0) begin
        got.imm_src = 2'b00;
        got.reg_src = 2'b00;
      end
      checks++;
      assert (got === exp_o) else begin
        failures++;
        $error("FAIL step instr=%h k=%0d observed=%h expected=%h", ins, k, got, exp_o);
      end
      aop = alu_of(ins[12:9]);
      if ((p[k] == 6 || p[k] == 7) && ins[8] && cond_holds(ins[19:16], m_flags) && aop >= 0)
      begin
        m_flags[3:2] = alu_flags[3:2];
        if (aop <= 1) m_flags[1:0] = alu_flags[1:0];
      end
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [19:0] rand_instr();
    logic [3:0] cond, cmd, rn, rd;
    logic [5:0] funct;
    logic [1:0] op;
    int         kind;
    cond  = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
    kind  = $urandom_range(0, 5);
    rn    = 4'($urandom);
    rd    = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
    funct = 6'($urandom);
    case (kind)
      0, 1: begin
        op = 2'b00;
        case ($urandom_range(0, 4))
          0: cmd = 4'b0100;
          1: cmd = 4'b0010;
          2: cmd = 4'b0000;
          3: cmd = 4'b1100;
          default: cmd = 4'($urandom);
        endcase
        funct = {(kind == 1) ? 1'b1 : 1'b0, cmd, 1'($urandom)};
      end
      2, 3: begin
        op = 2'b01;
        funct[0] = (kind == 2);
      end
      4: op = 2'b10;
      default: op = 2'b11;
    endcase
    return {cond, op, funct, rn, rd};
  endfunction

  initial begin
    reset     = 1'b1;
    instr     = 20'hE0812;
    alu_flags = 4'b0000;
    m_flags   = 4'b0000;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    assert ({state_o, pc_write, ir_write, mem_write, reg_write} === 8'h00) else begin
      failures++;
      $error("FAIL reset_idle observed=%h expected=00",
             {state_o, pc_write, ir_write, mem_write, reg_write});
    end
    reset = 1'b0;

    run_instr(20'hE0812, 1'b0, 4'h0, 99);  // ADD R2,R1,R0
    run_instr(20'hE5902, 1'b0, 4'h0, 99);  // LDR R2,[R0,#4]
    run_instr(20'hE5802, 1'b0, 4'h0, 99);  // STR R2,[R0,#4]
    run_instr(20'hE0500, 1'b1, 4'b0100, 99);  // SUBS R0,R0,R0 -> Z
    run_instr(20'h0A000, 1'b0, 4'h0, 99);  // BEQ taken
    run_instr(20'h1A000, 1'b0, 4'h0, 99);  // BNE not taken

    // Reset while a store is in MEMWR.
    run_instr(20'hE5802, 1'b0, 4'h0, 3);
    #1;
    checks++;
    assert (mem_write === 1'b1 && state_o === 4'd5) else begin
      failures++;
      $error("FAIL pre_reset_memwr observed=%b/%0d expected=1/5", mem_write, state_o);
    end
    reset = 1'b1;
    #1;
    checks++;
    assert (mem_write === 1'b0 && state_o === 4'd0) else begin
      failures++;
      $error("FAIL async_reset observed=%b/%0d expected=0/0", mem_write, state_o);
    end
    m_flags = 4'b0000;
    @(posedge clk);
    #1;
    checks++;
    assert ({state_o, pc_write, ir_write} === 6'h00) else begin
      failures++;
      $error("FAIL reset_hold observed=%h expected=00", {state_o, pc_write, ir_write});
    end
    reset = 1'b0;
    run_instr(20'h1A000, 1'b0, 4'h0, 99);  // BNE with cleared flags: taken
    run_instr(20'h0A000, 1'b0, 4'h0, 99);  // BEQ with cleared flags: not taken
    run_instr(20'hEF000, 1'b0, 4'h0, 99);  // op=11 no-op

`ifdef MCCTRL_MEMWAIT_EN
    mem_ready = 1'b0;
    instr     = 20'hE0812;
    for (int w = 0; w < 3; w++) begin
      #1;
      checks++;
      assert ({state_o, ir_write, pc_write} === 6'h00) else begin
        failures++;
        $error("FAIL fetch_wait observed=%h expected=00", {state_o, ir_write, pc_write});
      end
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    run_instr(20'hE0812, 1'b0, 4'h0, 99);
`endif

    for (int i = 0; i < 150; i++) run_instr(rand_instr(), 1'b0, 4'h0, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
